// File: rtl/spiker_stream_pkg.sv
// Shared types and sizing helpers for the spike stream reader.
// States, beat count and beat-index width are derived here so every user agrees on them.
package spiker_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Number of output beats needed to cover n_spikes bits, rounding up.
    function automatic int calc_n_beats(input int n_spikes, input int spikes_per_beat);
        return (n_spikes + spikes_per_beat - 1) / spikes_per_beat;
    endfunction

    // The index counter must be able to represent 0 .. n_beats.
    function automatic int beat_idx_width(input int n_beats);
        return $clog2(n_beats + 1);
    endfunction

endpackage

// File: rtl/spiker_stream_reader.sv
// Snapshots the spike register words and streams them to the neuron core as
// fixed-width beats over valid/ready, in LSB-first or MSB-first order.
module spiker_stream_reader
    import spiker_stream_pkg::*;
#(
    parameter int WORD_WIDTH      = 32,
    parameter int N_REG           = 25,
    parameter int N_SPIKES        = 784,
    parameter int SPIKES_PER_BEAT = 4,
    localparam int N_BEATS        = calc_n_beats(N_SPIKES, SPIKES_PER_BEAT),
    localparam int IDX_W          = beat_idx_width(N_BEATS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_REG*WORD_WIDTH-1:0]   regs_i,
    input  logic                          start_i,
    input  logic                          msb_first_i,
    input  logic                          abort_i,
    output logic [SPIKES_PER_BEAT-1:0]    spikes_o,
    output logic                          spikes_valid_o,
    input  logic                          spikes_ready_i,
    output logic [IDX_W-1:0]              beat_idx_o,
    output logic                          busy_o,
    output logic                          done_o
);

    // The shift register is padded to a whole number of beats; the pad bits are
    // zero so a partial last beat drives 0 in its out-of-range positions.
    localparam int              SH_W     = N_BEATS * SPIKES_PER_BEAT;
    localparam int              PAD      = SH_W - N_SPIKES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

    state_e             state_q;
    logic [SH_W-1:0]    shreg_q;
    logic               msb_q;
    logic [IDX_W-1:0]   idx_q;

    logic [SH_W-1:0]    snap_lsb;
    logic [SH_W-1:0]    snap_msb;
    logic               xfer;
    logic               unused_regs;

    // Snapshot bits above N_SPIKES-1 are dropped here and never emitted.
    assign snap_lsb    = SH_W'(regs_i[N_SPIKES-1:0]);
    assign snap_msb    = snap_lsb << PAD;
    assign unused_regs = ^regs_i;

    assign xfer = (state_q == ST_STREAM) && spikes_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
        end else if (abort_i) begin
            // Abort wins over start, transfer and the done handshake.
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        shreg_q <= msb_first_i ? snap_msb : snap_lsb;
                        msb_q   <= msb_first_i;
                        idx_q   <= '0;
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        shreg_q <= msb_q ? (shreg_q << SPIKES_PER_BEAT)
                                         : (shreg_q >> SPIKES_PER_BEAT);
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // The current beat sits at the end of the register the shift moves away from.
    assign spikes_o       = msb_q ? shreg_q[SH_W-1 -: SPIKES_PER_BEAT]
                                  : shreg_q[SPIKES_PER_BEAT-1:0];
    assign spikes_valid_o = (state_q == ST_STREAM);
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);
    assign beat_idx_o     = idx_q;

endmodule

// File: tb/tb_spiker_stream_reader.sv
// Directed bench for spiker_stream_reader: a default-size instance and a small
// instance with a partial last beat, checked against hand-computed beats.
module tb_spiker_stream_reader;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_i;

    // Default instance: 25 x 32-bit words, 784 spikes, 4 per beat, 196 beats.
    logic [799:0] regs;
    logic         start, msb, abort, ready;
    logic [3:0]   spikes;
    logic         valid, busy, done;
    logic [7:0]   idx;

    // Small instance: 10 spikes, 4 per beat, 3 beats.
    logic [31:0]  p_regs;
    logic         p_start, p_msb, p_abort, p_ready;
    logic [3:0]   p_spikes;
    logic         p_valid, p_busy, p_done;
    logic [1:0]   p_idx;

    int checks   = 0;
    int failures = 0;

    spiker_stream_reader dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .regs_i         (regs),
        .start_i        (start),
        .msb_first_i    (msb),
        .abort_i        (abort),
        .spikes_o       (spikes),
        .spikes_valid_o (valid),
        .spikes_ready_i (ready),
        .beat_idx_o     (idx),
        .busy_o         (busy),
        .done_o         (done)
    );

    spiker_stream_reader #(
        .WORD_WIDTH      (32),
        .N_REG           (1),
        .N_SPIKES        (10),
        .SPIKES_PER_BEAT (4)
    ) dut_p (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .regs_i         (p_regs),
        .start_i        (p_start),
        .msb_first_i    (p_msb),
        .abort_i        (p_abort),
        .spikes_o       (p_spikes),
        .spikes_valid_o (p_valid),
        .spikes_ready_i (p_ready),
        .beat_idx_o     (p_idx),
        .busy_o         (p_busy),
        .done_o         (p_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view {valid, done, busy, beat_idx, spikes} of each instance.
    function automatic logic [63:0] st_d();
        return {49'd0, valid, done, busy, idx, spikes};
    endfunction

    function automatic logic [63:0] ex_d(input logic v, input logic d, input logic b,
                                         input int i, input logic [3:0] s);
        return {49'd0, v, d, b, 8'(i), s};
    endfunction

    function automatic logic [63:0] st_p();
        return {55'd0, p_valid, p_done, p_busy, p_idx, p_spikes};
    endfunction

    function automatic logic [63:0] ex_p(input logic v, input logic d, input logic b,
                                         input int i, input logic [3:0] s);
        return {55'd0, v, d, b, 2'(i), s};
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    logic [3:0] p_lsb_exp [3] = '{4'hF, 4'hF, 4'h3};
    logic [3:0] p_msb_exp [3] = '{4'hF, 4'hF, 4'hC};
    logic [3:0] bp_pat        = 4'b1001;

    initial begin
        int acc;
        int cyc;
        logic [3:0] s;

        rst_i   = 1'b1;
        regs    = '0; start = 1'b0; msb = 1'b0; abort = 1'b0; ready = 1'b0;
        p_regs  = '0; p_start = 1'b0; p_msb = 1'b0; p_abort = 1'b0; p_ready = 1'b0;
        step();
        step();
        check("reset_default", st_d(), ex_d(0, 0, 0, 0, 4'h0));
        check("reset_partial", st_p(), ex_p(0, 0, 0, 0, 4'h0));
        rst_i = 1'b0;
        step();

        // LSB frame: 0xA5 in word 0 gives beats 5, A, then zeros.
        regs[7:0] = 8'hA5;
        ready     = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 196; k++) begin
            s = (k == 0) ? 4'h5 : (k == 1) ? 4'hA : 4'h0;
            check($sformatf("lsb_beat%0d", k), st_d(), ex_d(1, 0, 1, k, s));
            step();
        end
        check("lsb_done", st_d(), ex_d(0, 1, 1, 195, 4'h0));
        step();
        check("lsb_idle", st_d(), ex_d(0, 0, 0, 0, 4'h0));

        // MSB frame: bits 796..799 lie above N_SPIKES and are ignored; bit 783
        // leads beat 0, bit 0 lands in the low position of beat 195.
        regs             = '0;
        regs[799:768]    = 32'hF000_8000;
        regs[0]          = 1'b1;
        msb              = 1'b1;
        start            = 1'b1;
        step();
        start = 1'b0;
        msb   = 1'b0;
        regs  = '1;
        for (int k = 0; k < 196; k++) begin
            s = (k == 0) ? 4'h8 : (k == 195) ? 4'h1 : 4'h0;
            check($sformatf("msb_beat%0d", k), st_d(), ex_d(1, 0, 1, k, s));
            step();
        end
        check("msb_done", st_d(), ex_d(0, 1, 1, 195, 4'h0));
        step();
        check("msb_idle", st_d(), ex_d(0, 0, 0, 0, 4'h0));

        // Backpressure: ready pattern 1,0,0,1; beat k carries nibble k for k < 16.
        regs         = '0;
        regs[63:0]   = 64'hFEDC_BA98_7654_3210;
        start        = 1'b1;
        step();
        start = 1'b0;
        acc   = 0;
        cyc   = 0;
        while (acc < 196 && cyc < 2000) begin
            ready = bp_pat[cyc % 4];
            s     = (acc < 16) ? 4'(acc) : 4'h0;
            check($sformatf("bp_cyc%0d", cyc), st_d(), ex_d(1, 0, 1, acc, s));
            step();
            if (ready) acc++;
            cyc++;
        end
        check("bp_accepted", 64'(acc), 64'd196);
        check("bp_done", st_d(), ex_d(0, 1, 1, 195, 4'h0));
        ready = 1'b1;
        step();

        // Start during STREAM is ignored and the snapshot is unaffected; abort at beat 7.
        regs        = '0;
        regs[31:0]  = 32'h8765_4321;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                start = 1'b1;
                regs  = '0;
            end else begin
                start = 1'b0;
            end
            check($sformatf("ctl_beat%0d", k), st_d(), ex_d(1, 0, 1, k, 4'(k + 1)));
            if (k == 7) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        check("abort_idle", st_d(), ex_d(0, 0, 0, 0, 4'h0));
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("abort_no_done%0d", k), st_d(), ex_d(0, 0, 0, 0, 4'h0));
        end
        regs[31:0] = 32'h8765_4321;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_dropped", st_d(), ex_d(0, 0, 0, 0, 4'h0));
        step();
        check("start_abort_still_idle", st_d(), ex_d(0, 0, 0, 0, 4'h0));

        // Reset mid-frame at beat 50 (beat 50 = bits 200..203 set), then restart.
        regs          = '0;
        regs[203:200] = 4'hF;
        start         = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 50; k++) step();
        check("pre_reset_beat50", st_d(), ex_d(1, 0, 1, 50, 4'hF));
        #1 rst_i = 1'b1;
        #1;
        check("reset_mid_frame", st_d(), ex_d(0, 0, 0, 0, 4'h0));
        @(negedge clk_i);
        rst_i = 1'b0;
        step();
        check("post_reset_idle", st_d(), ex_d(0, 0, 0, 0, 4'h0));
        regs       = '0;
        regs[3:0]  = 4'h5;
        start      = 1'b1;
        step();
        start = 1'b0;
        check("restart_beat0", st_d(), ex_d(1, 0, 1, 0, 4'h5));
        step();
        check("restart_beat1", st_d(), ex_d(1, 0, 1, 1, 4'h0));
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Partial last beat on the 10-spike instance, both orders.
        p_regs  = '1;
        p_ready = 1'b1;
        p_start = 1'b1;
        step();
        p_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("p_lsb_beat%0d", k), st_p(), ex_p(1, 0, 1, k, p_lsb_exp[k]));
            step();
        end
        check("p_lsb_done", st_p(), ex_p(0, 1, 1, 2, 4'h0));
        step();
        p_msb   = 1'b1;
        p_start = 1'b1;
        step();
        p_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("p_msb_beat%0d", k), st_p(), ex_p(1, 0, 1, k, p_msb_exp[k]));
            step();
        end
        check("p_msb_done", st_p(), ex_p(0, 1, 1, 2, 4'h0));
        step();
        check("p_idle", st_p(), ex_p(0, 0, 0, 0, 4'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
